// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, busy
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_subtractor_if.slave  s
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_next;

  assign w_ai      = r_a[0];
  assign w_bi      = r_b[0];
  assign w_d       = w_ai ^ w_bi ^ r_br;
  assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (s.in_valid) begin
          w_accept = 1'b1;
          w_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (s.out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // r_acc collects bits while shifting so the visible diff only changes on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= s.a;
            r_b   <= s.b;
            r_acc <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_acc <= {w_d, r_acc[WIDTH-1:1]};
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff   <= {w_d, r_acc[WIDTH-1:1]};
            r_borrow <= w_br_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign s.in_ready  = rst_n && (r_state == IDLE);
  assign s.busy      = rst_n && (r_state == SHIFT);
  assign s.out_valid = rst_n && (r_state == DONE);
  assign s.diff      = r_diff;
  assign s.borrow    = r_borrow;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and randomized checks of serial_subtractor against an arithmetic model
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .s(bus));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a result is (a-b) mod 2^W with borrow a<b, visible W edges after acceptance
  bit           m_init = 1'b0;
  bit           m_pending = 1'b0;
  int           m_edges = 0;
  logic [W-1:0] m_res = '0;
  logic         m_br = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_borrow = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init    <= 1'b1;
      m_pending <= 1'b0;
      m_edges   <= 0;
      m_diff    <= '0;
      m_borrow  <= 1'b0;
    end else if (m_init) begin
      if (!m_pending) begin
        if (bus.in_valid) begin
          m_pending <= 1'b1;
          m_edges   <= 0;
          m_res     <= W'(bus.a - bus.b);
          m_br      <= (bus.a < bus.b);
        end
      end else if (m_edges < W) begin
        m_edges <= m_edges + 1;
        if (m_edges + 1 == W) begin
          m_diff   <= m_res;
          m_borrow <= m_br;
        end
      end else if (bus.out_ready) begin
        m_pending <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      #2;
      if (!rst_n) begin
        chk("cmp_in_ready_rst", bus.in_ready, 0);
        chk("cmp_busy_rst", bus.busy, 0);
        chk("cmp_out_valid_rst", bus.out_valid, 0);
      end else begin
        chk("cmp_in_ready", bus.in_ready, !m_pending);
        chk("cmp_busy", bus.busy, m_pending && (m_edges < W));
        chk("cmp_out_valid", bus.out_valid, m_pending && (m_edges == W));
      end
      chk("cmp_diff", bus.diff, m_diff);
      chk("cmp_borrow", bus.borrow, m_borrow);
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ed, input logic eb,
                       input int stall, input bit noisy);
    int n;
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = noisy;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    n = 0;
    while (!bus.out_valid && n < 4 * W) begin
      @(negedge clk);
      n++;
      if (!bus.out_valid) chk("busy_in_ready", bus.in_ready, 0);
      if (noisy) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
    end
    bus.in_valid = 1'b0;
    chk("latency", n, W);
    chk("result_diff", bus.diff, ed);
    chk("result_borrow", bus.borrow, eb);
    repeat (stall) begin
      @(negedge clk);
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_diff", bus.diff, ed);
      chk("hold_borrow", bus.borrow, eb);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("consume_out_valid", bus.out_valid, 0);
    chk("consume_in_ready", bus.in_ready, 1);
    chk("consume_diff_kept", bus.diff, ed);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_borrow", bus.borrow, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_in_ready", bus.in_ready, 1);

    do_op(8'h35, 8'h12, 8'h23, 1'b0, 0, 1'b0);
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, 0, 1'b0);
    do_op(8'h10, 8'h20, 8'hF0, 1'b1, 0, 1'b0);
    do_op(8'hAA, 8'hAA, 8'h00, 1'b0, 0, 1'b0);
    do_op(8'h00, 8'h05, 8'hFB, 1'b1, 0, 1'b0);
    do_op(8'hC3, 8'h41, 8'h82, 1'b0, 5, 1'b0);
    do_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 2, 1'b1);

    // abandon an operation with reset on its 4th shift edge
    bus.in_valid = 1'b1;
    bus.a        = 8'hFF;
    bus.b        = 8'h01;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_diff", bus.diff, 0);
    chk("midrst_borrow", bus.borrow, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_after", bus.in_ready, 1);
    repeat (W + 2) begin
      @(negedge clk);
      chk("midrst_no_out_valid", bus.out_valid, 0);
    end
    do_op(8'h80, 8'h7F, 8'h01, 1'b0, 0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.out_ready = ($urandom % 3) == 0;
      rst_n         = ($urandom % 300) != 0;
      @(negedge clk);
    end
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (W + 4) @(negedge clk);
    chk("drain_in_ready", bus.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  operands a, b present and requesting acceptance.
REQ-005 in_ready  output  1  block able to accept operands.
REQ-006 a  input  WIDTH  minuend, unsigned.
REQ-007 b  input  WIDTH  subtrahend, unsigned.
REQ-008 out_valid  output  1  diff and borrow hold a completed result.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 diff  output  WIDTH  (a - b) mod 2^WIDTH.
REQ-011 borrow  output  1  final borrow-out; 1 iff a < b.
REQ-012 busy  output  1  high while bits are being processed.

Function
REQ-013 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE with rst_n high; busy SHALL be 1 only in SHIFT; out_valid SHALL be 1 only in DONE.
REQ-015 Accept edge: a rising edge with in_valid && in_ready; the block SHALL latch a and b, clear the bit counter and internal borrow, and enter SHIFT.
REQ-016 a and b SHALL be ignored on every edge other than an accept edge; in_valid during SHIFT/DONE SHALL have no effect.
REQ-017 Each SHIFT edge SHALL process one bit, LSB first, as a half-subtractor plus borrow: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-018 Each d SHALL be shifted into the result register from the MSB end, so that after WIDTH shifts bit i of diff equals the bit-i result.
REQ-019 After exactly WIDTH SHIFT edges the FSM SHALL enter DONE with diff and borrow final; out_valid SHALL first be high after the WIDTH-th edge following the accept edge.
REQ-020 diff and borrow SHALL be stable while out_valid is high, for any duration of out_ready low.
REQ-021 On an edge with out_valid && out_ready the FSM SHALL return to IDLE; diff and borrow SHALL hold their values until the next result completes.
REQ-022 No operand SHALL be accepted on the same edge that a result is consumed; minimum accept-to-accept spacing is WIDTH+2 edges.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide, with no wrap-around inside one operation.
REQ-024 Equal operands SHALL give diff 0 and borrow 0; a = 0 with b != 0 SHALL give borrow 1.

Reset
REQ-025 When rst_n is low at a rising edge, the FSM SHALL go to IDLE and clear diff, borrow, the internal borrow, the counter and the operand registers to 0.
REQ-026 While rst_n is low, in_ready, out_valid and busy SHALL be 0.
REQ-027 Reset asserted during SHIFT or DONE SHALL abandon the operation; no out_valid SHALL follow for that operation.
REQ-028 in_ready SHALL be 1 on the first cycle with rst_n high after reset.

Verification (WIDTH = 8)
REQ-029 The bench SHALL cover basic subtraction: accept a=0x35, b=0x12 -> out_valid high after 8th edge post-accept, diff=0x23, borrow=0.
REQ-030 The bench SHALL cover underflow: a=0x00, b=0x01 -> diff=0xFF, borrow=1; also a=0x10, b=0x20 -> diff=0xF0, borrow=1.
REQ-031 The bench SHALL cover equal operands: a=0xAA, b=0xAA -> diff=0x00, borrow=0.
REQ-032 The bench SHALL cover backpressure: out_ready held low for 5 cycles in DONE -> out_valid, diff and borrow constant, in_ready 0 throughout; out_ready high -> IDLE next edge, in_ready 1.
REQ-033 The bench SHALL cover reset mid-operation: rst_n low at the 4th SHIFT edge of a=0xFF, b=0x01 -> all outputs 0, IDLE, no out_valid; the next operation a=0x80, b=0x7F -> diff=0x01, borrow=0.
REQ-034 The bench SHALL cover operand changes while busy: in_valid held high with a/b changing during SHIFT -> result reflects the latched operands only; no second accept until IDLE.
